// File: rtl/ucsbece154b_branch_if.sv
// ucsbece154b_branch_if: fetch-side prediction and execute-side resolution signals of the branch predictor
interface ucsbece154b_branch_if #(
  parameter int NUM_GHR_BITS = 5
);
  logic [31:0]             pc_i;
  logic                    BranchTaken_o;
  logic [31:0]             BTBtarget_o;
  logic [NUM_GHR_BITS-1:0] PHTindexF_o;
  logic [6:0]              op_i;
  logic [31:0]             PCE_i;
  logic [31:0]             BranchTargetE_i;
  logic                    PCSrcE_i;
  logic [NUM_GHR_BITS-1:0] PHTindexE_i;
  modport master (
    output pc_i, op_i, PCE_i, BranchTargetE_i, PCSrcE_i, PHTindexE_i,
    input  BranchTaken_o, BTBtarget_o, PHTindexF_o
  );
  modport slave (
    input  pc_i, op_i, PCE_i, BranchTargetE_i, PCSrcE_i, PHTindexE_i,
    output BranchTaken_o, BTBtarget_o, PHTindexF_o
  );
endinterface

// File: rtl/ucsbece154b_branch.sv
// ucsbece154b_branch: direct-mapped BTB plus 2-bit counter PHT; bimodal by default,
// gshare indexing when UCSBECE154B_GSHARE_EN is defined.
module ucsbece154b_branch #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic clk,
  input  logic reset,
  ucsbece154b_branch_if.slave bp
);
  localparam int IW = $clog2(NUM_BTB_ENTRIES);
  localparam int TW = 30 - IW;
  localparam int PD = 1 << NUM_GHR_BITS;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  logic [NUM_BTB_ENTRIES-1:0] valid_q;
  logic [NUM_BTB_ENTRIES-1:0] j_q;
  logic [NUM_BTB_ENTRIES-1:0] b_q;
  logic [TW-1:0]              tag_q [NUM_BTB_ENTRIES];
  logic [31:0]                target_q [NUM_BTB_ENTRIES];
  logic [1:0]                 pht_q [PD];
  logic [IW-1:0]              idx_f, idx_e;
  logic [NUM_GHR_BITS-1:0]    phtf;
  logic [1:0]                 ctr, ctr_d;
  logic                       hit, is_br, is_jal, upd;
  logic                       unused_bits;
  assign unused_bits = ^{bp.pc_i[1:0], bp.PCE_i[1:0]};
  assign idx_f  = bp.pc_i[IW+1:2];
  assign idx_e  = bp.PCE_i[IW+1:2];
  assign is_br  = bp.op_i == OP_BRANCH;
  assign is_jal = bp.op_i == OP_JAL;
  assign upd    = is_br || is_jal;
`ifdef UCSBECE154B_GSHARE_EN
  logic [NUM_GHR_BITS-1:0] ghr_q, ghr_d;
  assign ghr_d = is_br ? {ghr_q[NUM_GHR_BITS-2:0], bp.PCSrcE_i} : ghr_q;
  assign phtf  = bp.pc_i[NUM_GHR_BITS+1:2] ^ ghr_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  assign phtf = bp.pc_i[NUM_GHR_BITS+1:2];
`endif
  // Lookup reads the registered arrays directly, so a same-cycle write is seen only next cycle.
  always_comb begin
    hit              = valid_q[idx_f] && (tag_q[idx_f] == bp.pc_i[31:IW+2]);
    bp.PHTindexF_o   = phtf;
    bp.BranchTaken_o = hit && (j_q[idx_f] || (b_q[idx_f] && pht_q[phtf][1]));
    bp.BTBtarget_o   = hit ? target_q[idx_f] : 32'b0;
  end
  always_comb begin
    ctr   = pht_q[bp.PHTindexE_i];
    ctr_d = bp.PCSrcE_i ? ((ctr == 2'b11) ? ctr : ctr + 2'b01)
                        : ((ctr == 2'b00) ? ctr : ctr - 2'b01);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < PD; i++) pht_q[i] <= 2'b01;
    end else begin
      if (upd) valid_q[idx_e] <= 1'b1;
      if (is_br) pht_q[bp.PHTindexE_i] <= ctr_d;
    end
  end
  // Payload is only meaningful behind valid; gating on reset keeps a reset edge from writing it.
  always_ff @(posedge clk) begin
    if (reset && upd) begin
      tag_q[idx_e]    <= bp.PCE_i[31:IW+2];
      target_q[idx_e] <= bp.BranchTargetE_i;
      j_q[idx_e]      <= is_jal;
      b_q[idx_e]      <= is_br;
    end
  end
endmodule

// File: doc/ucsbece154b_branch.md
UCSBECE154B_BRANCH -- requirements
Module: ucsbece154b_branch

Interface
REQ-001 SHALL provide parameter NUM_BTB_ENTRIES, default 32: direct-mapped BTB depth, power of two.
REQ-002 SHALL provide parameter NUM_GHR_BITS, default 5: GHR width; PHT depth = 2^NUM_GHR_BITS.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low (state cleared while 0).
REQ-005 SHALL have port pc_i  in  32  fetch-stage PC.
REQ-006 SHALL have port BranchTaken_o  out  1  fetch prediction: redirect to BTBtarget_o.
REQ-007 SHALL have port BTBtarget_o  out  32  predicted target.
REQ-008 SHALL have port PHTindexF_o  out  NUM_GHR_BITS  PHT index used for this fetch; the pipeline carries it to execute.
REQ-009 SHALL have port op_i  in  7  execute-stage opcode; bubbles carry 7'b0.
REQ-010 SHALL have port PCE_i  in  32  execute-stage PC.
REQ-011 SHALL have port BranchTargetE_i  in  32  resolved target of the execute-stage instruction.
REQ-012 SHALL have port PCSrcE_i  in  1  execute-stage actual-taken.
REQ-013 SHALL have port PHTindexE_i  in  NUM_GHR_BITS  PHT index returned from execute.

Function
REQ-014 SHALL index the BTB with pc_i[log2(NUM_BTB_ENTRIES)+1:2]; tag = remaining upper PC bits [31:log2+2]; entry = valid, tag, target[31:0], J bit, B bit.
REQ-015 SHALL compute hit = valid && tag match, combinationally in the same cycle as pc_i (zero-cycle lookup latency).
REQ-016 SHALL drive BranchTaken_o = hit && (J || (B && PHT[PHTindexF_o][1])).
REQ-017 SHALL drive BTBtarget_o = entry target on hit and 32'b0 on miss.
REQ-018 SHALL classify opcode 1100011 as branch and 1101111 (jal) as jump; jalr and all other opcodes SHALL leave all state unchanged.
REQ-019 SHALL, on a branch or jump in execute, write the BTB entry at PCE_i's index: valid=1, tag from PCE_i, target=BranchTargetE_i, J/B per type; this overwrites any aliasing entry.
REQ-020 SHALL, on a branch, update the 2-bit PHT counter at PHTindexE_i: +1 if PCSrcE_i else -1, saturating at 3 and 0.
REQ-021 SHALL, on a branch only, shift the GHR left by one, inserting PCSrcE_i at bit 0; the oldest bit is dropped.
REQ-022 SHALL return pre-update contents on a same-cycle fetch read of an entry being written; the new value SHALL be visible from the next cycle.
REQ-023 SHALL treat simultaneous BTB and PHT updates from one instruction as a single atomic edge.

Reset
REQ-024 SHALL, while reset=0, asynchronously clear all BTB valid bits, set all PHT counters to 2'b01 (weakly not-taken), and clear the GHR.
REQ-025 SHALL therefore drive BranchTaken_o=0 and BTBtarget_o=0 during and immediately after reset.
REQ-026 SHALL, on reset mid-operation, discard any update pending on that edge; no partial entry write is allowed.

Configuration
REQ-027 SHALL honour macro UCSBECE154B_GSHARE_EN. When defined: PHTindexF_o = pc_i[NUM_GHR_BITS+1:2] XOR GHR. When undefined: PHTindexF_o = pc_i[NUM_GHR_BITS+1:2], and the GHR is not instantiated (bimodal predictor).

Verification
REQ-028 SHALL pass: after reset, pc_i=0x0000_0010 -> BranchTaken_o=0, BTBtarget_o=0, PHTindexF_o=5'd4.
REQ-029 SHALL pass: jal in execute (op_i=1101111, PCE_i=0x20, BranchTargetE_i=0x80); next cycle pc_i=0x20 -> BranchTaken_o=1, BTBtarget_o=0x80.
REQ-030 SHALL pass: branch at PC 0x40, target 0x10, resolved taken twice (same PHTindexE_i) -> counter goes 01->10->11; fetch 0x40 with matching index -> BranchTaken_o=1. Four not-taken updates -> counter=00, BranchTaken_o=0.
REQ-031 SHALL pass: entry for 0x40 exists; jump at 0x0C0 aliases index (32 entries) -> 0x40 lookup misses (tag mismatch), 0x0C0 hits.
REQ-032 SHALL pass: jalr opcode 1100111 in execute with PCSrcE_i=1 -> BTB, PHT and GHR unchanged.
REQ-033 SHALL pass with UCSBECE154B_GSHARE_EN defined: branch outcomes T,T,N from reset -> GHR=5'b00110; pc_i=0x0 -> PHTindexF_o=5'b00110. Reset asserted mid-sequence -> GHR=0 immediately.
